if_id_queue: RTL

- Instruction buffer between the IF stage and the ID stage of the dual-issue MIPS core.
- Holds fetched entries as {PC, inst, IC} until ID consumes them, so decode stalls do not require IF to refetch.
- Raises a stall to IF when the queue is nearly full.
- Clears all contents on a flush caused by an exception, an interrupt or a taken branch/jump redirect.

---
 rtl/if_id_queue_if.sv | 39 +++
 rtl/if_id_queue.sv | 91 +++++++++
 2 files changed

// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue_if
//  Description : Handshake bundle between the IF stage, the IF/ID instruction
//                queue and the ID stage.
//                master  = IF/ID pipeline side (pushes and pops entries)
//                slave   = the queue itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_id_queue_if #(
   parameter int PTR_W = 2
);
   // IF -> queue
   logic             in_valid;
   logic [31:0]      in_PC;
   logic [31:0]      in_inst;
   logic [1:0]       in_IC;
   logic             in_ready;
   // queue -> ID
   logic             out_valid;
   logic [31:0]      out_PC;
   logic [31:0]      out_inst;
   logic [1:0]       out_IC;
   logic             out_ready;
   // status
   logic             fetch_stall;
   logic [PTR_W:0]   count;

   modport master (
      output in_valid, in_PC, in_inst, in_IC, out_ready,
      input  in_ready, out_valid, out_PC, out_inst, out_IC, fetch_stall, count
   );

   modport slave (
      input  in_valid, in_PC, in_inst, in_IC, out_ready,
      output in_ready, out_valid, out_PC, out_inst, out_IC, fetch_stall, count
   );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : Show-ahead instruction queue between IF and ID. Entries are
//                {PC, inst, IC}. Requests IF to stall one entry before full
//                and drops all contents on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  wire             clk,
   input  wire             reset,
   input  wire             flush,
   if_id_queue_if.slave    q
);

   localparam logic [PTR_W:0] C_FULL      = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] C_NEAR_FULL = (PTR_W+1)'(DEPTH - 1);
   localparam logic [PTR_W:0] C_EMPTY     = '0;

   // Storage is intentionally never cleared; validity is tracked by r_count.
   logic [65:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic             w_not_full;
   logic             w_not_empty;
   logic             w_push;
   logic             w_pop;
   logic [65:0]      w_head;

   assign w_not_full  = (r_count != C_FULL);
   assign w_not_empty = (r_count != C_EMPTY);
   // Push is refused whenever full, even if a pop happens in the same cycle.
   assign w_push      = q.in_valid && w_not_full;
   assign w_pop       = w_not_empty && q.out_ready;

   // Pointer and occupancy update; flush discards any same-cycle push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry write at the tail; no reset so the array maps onto plain storage.
   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_mem[r_wr_ptr] <= {q.in_PC, q.in_inst, q.in_IC};
      end
   end

   // Show-ahead head entry, zeroed while the queue is empty.
   always_comb begin
      w_head = '0;
      if (w_not_empty) begin
         w_head = r_mem[r_rd_ptr];
      end
   end

   assign q.in_ready    = w_not_full;
   assign q.out_valid   = w_not_empty;
   assign q.out_PC      = w_head[65:34];
   assign q.out_inst    = w_head[33:2];
   assign q.out_IC      = w_head[1:0];
   // Stall one entry early to cover IF's one-cycle PC hold latency.
   assign q.fetch_stall = (r_count >= C_NEAR_FULL);
   assign q.count       = r_count;

endmodule
`default_nettype wire
